// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with mid-bit sampling and one-cycle valid/error strobes.
// Define UART_RX_PARITY_EN to receive 8E1 frames with an even-parity check.
module uart_rx #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 9600
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_busy,
    output logic       rx_frame_err,
    output logic       rx_parity_err
);

    localparam int N     = CLK_FREQ / BAUD_RATE;
    localparam int H     = N / 2;
    localparam int CNT_W = $clog2(N);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(H - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [2:0]       bit_idx, bit_next;
    logic [7:0]       shift_reg, shift_next;
    logic [7:0]       data_next;
    logic             valid_next;
    logic             ferr_next;
    logic             rxd_m, rxd_s;

`ifdef UART_RX_PARITY_EN
    logic parity_bad, parity_bad_next;
    logic perr_next;
`endif

    // Two-stage synchronizer; resets to the idle line level so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments give every flop the pre-edge value of its source,
            // which is what makes this a two-stage chain rather than one wire.
            rxd_m <= uart_rxd;
            rxd_s <= rxd_m;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            cnt          <= '0;
            bit_idx      <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            state        <= state_next;
            cnt          <= cnt_next;
            bit_idx      <= bit_next;
            rx_data      <= data_next;
            rx_valid     <= valid_next;
            rx_frame_err <= ferr_next;
        end
    end

    // NOTE: the shift register is left out of reset on purpose; all eight bits are
    // overwritten before rx_data can ever be loaded from it.
    always_ff @(posedge clk) begin
        shift_reg <= shift_next;
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            parity_bad    <= 1'b0;
            rx_parity_err <= 1'b0;
        end else begin
            parity_bad    <= parity_bad_next;
            rx_parity_err <= perr_next;
        end
    end
`else
    assign rx_parity_err = 1'b0;
`endif

    assign rx_busy = (state != S_IDLE);

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned,
        // which would otherwise infer a latch.
        state_next = state;
        cnt_next   = cnt + CNT_W'(1);
        bit_next   = bit_idx;
        shift_next = shift_reg;
        data_next  = rx_data;
        valid_next = 1'b0;
        ferr_next  = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_bad_next = parity_bad;
        perr_next       = 1'b0;
`endif

        case (state)
            S_IDLE: begin
                cnt_next = '0;
                if (!rxd_s) begin
                    state_next = S_START;
                end
            end

            S_START: begin
                if (cnt == HALF_LAST) begin
                    cnt_next   = '0;
                    bit_next   = '0;
                    // A start bit that has gone high again by mid-bit is a glitch.
                    state_next = rxd_s ? S_IDLE : S_DATA;
                end
            end

            S_DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_next   = '0;
                    shift_next = {rxd_s, shift_reg[7:1]};
                    bit_next   = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_next = S_PARITY;
`else
                        state_next = S_STOP;
`endif
                    end
                end
            end

`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (cnt == BIT_LAST) begin
                    cnt_next        = '0;
                    parity_bad_next = ^{shift_reg, rxd_s};
                    state_next      = S_STOP;
                end
            end
`endif

            S_STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_next = '0;
                    if (rxd_s) begin
                        data_next  = shift_reg;
                        valid_next = 1'b1;
`ifdef UART_RX_PARITY_EN
                        perr_next  = parity_bad;
`endif
                        state_next = S_IDLE;
                    end else begin
                        ferr_next  = 1'b1;
                        state_next = S_WAIT_HIGH;
                    end
                end
            end

            S_WAIT_HIGH: begin
                // Hold off until a break or stuck-low line releases.
                cnt_next = '0;
                if (rxd_s) begin
                    state_next = S_IDLE;
                end
            end

            default: begin
                cnt_next   = '0;
                state_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed self-checking bench for uart_rx at N=16, H=8.
// Expected strobe cycles are counted from the cycle uart_rxd is first driven low (2-cycle synchronizer + T0 latency).
module tb_uart_rx;

    localparam int CLK_FREQ  = 1_600_000;
    localparam int BAUD_RATE = 100_000;
    localparam int N         = 16;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS = 11;
    localparam int LAT   = 2 + 169;
`else
    localparam int NBITS = 10;
    localparam int LAT   = 2 + 153;
`endif
    localparam int FRAME_CYC = NBITS * N;

    logic       clk = 1'b0;
    logic       reset;
    logic       uart_rxd;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_busy;
    logic       rx_frame_err;
    logic       rx_parity_err;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    int         valid_cyc[$];
    logic [7:0] valid_dat[$];
    int         ferr_cyc[$];
    int         perr_cyc[$];
    int         rise_cyc[$];
    int         fall_cyc[$];
    int         both_cnt   = 0;
    int         perr_total = 0;
    logic       busy_prev  = 1'b0;

    uart_rx #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD_RATE(BAUD_RATE)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .uart_rxd     (uart_rxd),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_busy      (rx_busy),
        .rx_frame_err (rx_frame_err),
        .rx_parity_err(rx_parity_err)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Event recorder, sampled 1 time unit after each rising edge.
    initial forever begin
        @(posedge clk);
        #1;
        if (rx_valid === 1'b1) begin
            valid_cyc.push_back(cyc);
            valid_dat.push_back(rx_data);
        end
        if (rx_frame_err === 1'b1) ferr_cyc.push_back(cyc);
        if (rx_parity_err === 1'b1) begin
            perr_cyc.push_back(cyc);
            perr_total++;
        end
        if (rx_valid === 1'b1 && rx_frame_err === 1'b1) both_cnt++;
        if (rx_busy === 1'b1 && !busy_prev) rise_cyc.push_back(cyc);
        if (rx_busy === 1'b0 && busy_prev) fall_cyc.push_back(cyc);
        busy_prev = (rx_busy === 1'b1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic clear_mon();
        valid_cyc.delete();
        valid_dat.delete();
        ferr_cyc.delete();
        perr_cyc.delete();
        rise_cyc.delete();
        fall_cyc.delete();
    endtask

    function automatic logic [10:0] make_frame(input logic [7:0] d, input logic stop, input logic par);
`ifdef UART_RX_PARITY_EN
        return {stop, par, d, 1'b0};
`else
        return {par, stop, d, 1'b0};
`endif
    endfunction

    task automatic drive_bits(input logic [10:0] f, input int count);
        for (int i = 0; i < count; i++) begin
            uart_rxd = f[i];
            repeat (N) @(negedge clk);
        end
    endtask

    // Called on a falling edge; returns the cycle in which the start bit was driven.
    task automatic send(input logic [7:0] d, input logic stop, input logic par, output int start);
        start = cyc;
        drive_bits(make_frame(d, stop, par), NBITS);
    endtask

    task automatic expect_one(input string tag, input logic [7:0] d, input int start);
        check({tag, "_count"}, valid_cyc.size(), 1);
        if (valid_cyc.size() > 0) begin
            check({tag, "_data"}, valid_dat[0], d);
            check({tag, "_cycle"}, valid_cyc[0], start + LAT);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_data"}, rx_data, 0);
        check({tag, "_valid"}, rx_valid, 0);
        check({tag, "_busy"}, rx_busy, 0);
        check({tag, "_ferr"}, rx_frame_err, 0);
        check({tag, "_perr"}, rx_parity_err, 0);
    endtask

    initial begin
        int         st;
        int         st2;
        int         h;
        logic [7:0] tmp;
        logic [10:0] f;

        reset    = 1'b1;
        uart_rxd = 1'b1;
        repeat (3) @(negedge clk);
        check_outputs_zero("rst");
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check_outputs_zero("post_rst");

        // Good frame 0xA5 with busy window T0+1 .. T0+152.
        clear_mon();
        tmp = 8'hA5;
        send(tmp, 1'b1, ^tmp, st);
        repeat (20) @(negedge clk);
        expect_one("a5", 8'hA5, st);
        check("a5_busy_rise", rise_cyc.size() > 0 ? rise_cyc[0] : -1, st + 3);
        check("a5_busy_fall", fall_cyc.size() > 0 ? fall_cyc[0] : -1, st + LAT);
        check("a5_no_ferr", ferr_cyc.size(), 0);

        // Frame error: 0x3C with stop low, line held low 50 more cycles.
        clear_mon();
        tmp = 8'h3C;
        send(tmp, 1'b0, ^tmp, st);
        repeat (50) @(negedge clk);
        check("ferr_busy_held", rx_busy, 1);
        check("ferr_count", ferr_cyc.size(), 1);
        check("ferr_cycle", ferr_cyc.size() > 0 ? ferr_cyc[0] : -1, st + LAT);
        check("ferr_no_valid", valid_cyc.size(), 0);
        check("ferr_no_perr", perr_cyc.size(), 0);
        check("ferr_data_kept", rx_data, 8'hA5);
        h = cyc;
        uart_rxd = 1'b1;
        repeat (10) @(negedge clk);
        check("ferr_busy_release", fall_cyc.size() > 0 ? fall_cyc[0] : -1, h + 3);
        clear_mon();
        tmp = 8'h5A;
        send(tmp, 1'b1, ^tmp, st);
        repeat (20) @(negedge clk);
        expect_one("after_ferr_5a", 8'h5A, st);

        // Glitch: 4-cycle low pulse is rejected at the START sample.
        clear_mon();
        st = cyc;
        uart_rxd = 1'b0;
        repeat (4) @(negedge clk);
        uart_rxd = 1'b1;
        repeat (30) @(negedge clk);
        check("glitch_busy_rise", rise_cyc.size() > 0 ? rise_cyc[0] : -1, st + 3);
        check("glitch_busy_fall", fall_cyc.size() > 0 ? fall_cyc[0] : -1, st + 11);
        check("glitch_no_valid", valid_cyc.size(), 0);
        check("glitch_no_ferr", ferr_cyc.size(), 0);
        clear_mon();
        tmp = 8'h3C;
        send(tmp, 1'b1, ^tmp, st);
        repeat (20) @(negedge clk);
        expect_one("after_glitch_3c", 8'h3C, st);

        // Back-to-back frames with zero idle gap.
        clear_mon();
        tmp = 8'h00;
        send(tmp, 1'b1, ^tmp, st);
        tmp = 8'hFF;
        send(tmp, 1'b1, ^tmp, st2);
        repeat (20) @(negedge clk);
        check("b2b_count", valid_cyc.size(), 2);
        if (valid_cyc.size() == 2) begin
            check("b2b_data0", valid_dat[0], 8'h00);
            check("b2b_data1", valid_dat[1], 8'hFF);
            check("b2b_cycle0", valid_cyc[0], st + LAT);
            check("b2b_spacing", valid_cyc[1] - valid_cyc[0], FRAME_CYC);
        end

        // Reset during data bit 3 of 0x77.
        clear_mon();
        tmp = 8'h77;
        f = make_frame(tmp, 1'b1, ^tmp);
        drive_bits(f, 4);
        uart_rxd = f[4];
        repeat (8) @(negedge clk);
        check("mid_busy_before", rx_busy, 1);
        reset    = 1'b1;
        uart_rxd = 1'b1;
        repeat (2) @(negedge clk);
        check_outputs_zero("mid_rst");
        reset = 1'b0;
        repeat (200) @(negedge clk);
        check("mid_no_valid", valid_cyc.size(), 0);
        check("mid_no_ferr", ferr_cyc.size(), 0);
        check("mid_idle_busy", rx_busy, 0);
        clear_mon();
        tmp = 8'h81;
        send(tmp, 1'b1, ^tmp, st);
        repeat (20) @(negedge clk);
        expect_one("after_mid_81", 8'h81, st);

`ifdef UART_RX_PARITY_EN
        // 0x07 has odd weight: parity bit 0 is a mismatch, 1 is correct.
        clear_mon();
        send(8'h07, 1'b1, 1'b0, st);
        repeat (20) @(negedge clk);
        expect_one("par_bad", 8'h07, st);
        check("par_bad_perr_count", perr_cyc.size(), 1);
        check("par_bad_perr_cycle", perr_cyc.size() > 0 ? perr_cyc[0] : -1, st + LAT);
        clear_mon();
        send(8'h07, 1'b1, 1'b1, st);
        repeat (20) @(negedge clk);
        expect_one("par_good", 8'h07, st);
        check("par_good_no_perr", perr_cyc.size(), 0);
        check("perr_total", perr_total, 1);
`else
        check("perr_never", perr_total, 0);
`endif
        check("valid_ferr_overlap", both_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
